// File: rtl/c_bit_packer.sv
// Bit-field packer: appends left-justified fields of up to IN_WIDTH bits into OUT_WIDTH-bit words.
// Optional macro C_BIT_PACKER_CHECK_EN adds a sticky error port and clamps oversized in_count.
module c_bit_packer #(
   parameter int unsigned IN_WIDTH  = 8,
   parameter int unsigned OUT_WIDTH = 32
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [IN_WIDTH-1:0]                    in_data,
   input  logic [$clog2(IN_WIDTH+1)-1:0]          in_count,
   input  logic                                   in_last,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [OUT_WIDTH-1:0]                   out_data,
   output logic [$clog2(OUT_WIDTH+1)-1:0]         out_count,
   output logic                                   out_last
`ifdef C_BIT_PACKER_CHECK_EN
   ,
   output logic                                   error
`endif
);

   localparam int unsigned BUF_W  = 2*OUT_WIDTH + IN_WIDTH - 1;
   localparam int unsigned CNT_W  = $clog2(IN_WIDTH+1);
   localparam int unsigned FILL_W = $clog2(BUF_W+1);
   localparam int unsigned OCNT_W = $clog2(OUT_WIDTH+1);

   typedef enum logic {RUN, FLUSH} state_t;

   // First bit of a field/word sits in the MSB of the vector.
   logic [BUF_W-1:0]  r_buf;
   logic [FILL_W-1:0] r_fill;
   state_t            r_state;
   logic              r_in_ready;
   logic              r_out_valid;
   logic              r_out_last;
   logic [OCNT_W-1:0] r_out_count;

   logic              w_in_fire;
   logic              w_out_fire;
   logic [CNT_W-1:0]  w_cnt;
   logic [IN_WIDTH-1:0] w_mask;
   logic [BUF_W-1:0]  w_field;
   logic [BUF_W-1:0]  w_buf_nxt;
   logic [FILL_W-1:0] w_fill_nxt;
   state_t            w_state_nxt;

   // Shift out a word first, then append the new field at the post-shift fill.
   always_comb begin
      w_in_fire  = in_valid & r_in_ready;
      w_out_fire = r_out_valid & out_ready;
      w_cnt      = in_count;
`ifdef C_BIT_PACKER_CHECK_EN
      if (in_count > CNT_W'(IN_WIDTH)) w_cnt = CNT_W'(IN_WIDTH);
`endif
      w_mask      = ~({IN_WIDTH{1'b1}} >> w_cnt);
      w_field     = {in_data & w_mask, {(BUF_W-IN_WIDTH){1'b0}}};
      w_buf_nxt   = r_buf;
      w_fill_nxt  = r_fill;
      w_state_nxt = r_state;
      if (w_out_fire) begin
         w_buf_nxt  = r_buf << OUT_WIDTH;
         w_fill_nxt = (r_fill >= FILL_W'(OUT_WIDTH)) ? r_fill - FILL_W'(OUT_WIDTH) : '0;
         if (r_out_last) w_state_nxt = RUN;
      end
      if (w_in_fire) begin
         w_buf_nxt  = w_buf_nxt | (w_field >> w_fill_nxt);
         w_fill_nxt = w_fill_nxt + FILL_W'(w_cnt);
         if (in_last) w_state_nxt = FLUSH;
      end
   end

   // Handshake flags are registered from the next-state values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_buf       <= '0;
         r_fill      <= '0;
         r_state     <= RUN;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_count <= '0;
      end else begin
         r_buf       <= w_buf_nxt;
         r_fill      <= w_fill_nxt;
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt == RUN) && (w_fill_nxt < FILL_W'(2*OUT_WIDTH));
         r_out_valid <= (w_fill_nxt >= FILL_W'(OUT_WIDTH)) || (w_state_nxt == FLUSH);
         r_out_last  <= (w_state_nxt == FLUSH) && (w_fill_nxt <= FILL_W'(OUT_WIDTH));
         r_out_count <= (w_fill_nxt >= FILL_W'(OUT_WIDTH)) ? OCNT_W'(OUT_WIDTH)
                                                          : OCNT_W'(w_fill_nxt);
      end
   end

`ifdef C_BIT_PACKER_CHECK_EN
   logic r_error;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                          r_error <= 1'b0;
      else if (w_in_fire && (in_count > CNT_W'(IN_WIDTH)))   r_error <= 1'b1;
   end

   assign error = r_error;
`endif

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign out_count = r_out_count;
   assign out_data  = r_buf[BUF_W-1 -: OUT_WIDTH];

endmodule

// File: tb/tb_c_bit_packer.sv
// Testbench for c_bit_packer (in_width=8, out_width=32): directed vector table,
// corner sequences and randomized traffic against a bit-queue frame model.
module tb_c_bit_packer;
   localparam int unsigned IW  = 8;
   localparam int unsigned OW  = 32;
   localparam int unsigned CW  = 4;
   localparam int unsigned OCW = 6;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           in_valid;
   logic           in_ready;
   logic [IW-1:0]  in_data;
   logic [CW-1:0]  in_count;
   logic           in_last;
   logic           out_valid;
   logic           out_ready;
   logic [OW-1:0]  out_data;
   logic [OCW-1:0] out_count;
   logic           out_last;
`ifdef C_BIT_PACKER_CHECK_EN
   logic           error;
`endif

   c_bit_packer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_count(in_count), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_count(out_count), .out_last(out_last)
`ifdef C_BIT_PACKER_CHECK_EN
      , .error(error)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] data;
      int          count;
      bit          last;
      longint      cyc;
   } word_t;

   word_t act_q[$];
   word_t exp_q[$];
   bit    frame_bits[$];

   typedef struct {
      int              n;
      logic [3:0][7:0] d;
      logic [3:0][3:0] c;
      logic [31:0]     e_data;
      int              e_cnt;
   } vec_t;
   vec_t tbl[5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Output monitor: records fired words, checks outputs hold under backpressure.
   logic [31:0] h_data;
   int          h_cnt;
   bit          h_last;
   bit          h_pend = 1'b0;
   always @(negedge clk) begin
      if (!reset_n) begin
         h_pend = 1'b0;
      end else begin
         if (h_pend) begin
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_data",  64'(out_data),  64'(h_data));
            check("hold_count", 64'(out_count), 64'(h_cnt));
            check("hold_last",  64'(out_last),  64'(h_last));
         end
         if (out_valid && out_ready)
            act_q.push_back('{out_data, int'(out_count), out_last, cyc});
         h_pend = out_valid && !out_ready;
         h_data = out_data;
         h_cnt  = int'(out_count);
         h_last = out_last;
      end
   end

   bit rnd_ready = 1'b0;
   always @(posedge clk) if (rnd_ready) begin
      #1 out_ready = ($urandom_range(0, 2) != 0);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: a frame is a bit string cut into 32-bit words, last one zero-padded.
   task automatic emit_frame();
      int L = frame_bits.size();
      if (L == 0) begin
         exp_q.push_back('{32'h0, 0, 1'b1, 0});
      end else begin
         int nw = (L + 31) / 32;
         for (int w = 0; w < nw; w++) begin
            logic [31:0] d = '0;
            int cnt = (L - 32*w > 32) ? 32 : L - 32*w;
            for (int k = 0; k < cnt; k++) d[31-k] = frame_bits[32*w+k];
            exp_q.push_back('{d, cnt, (w == nw-1), 0});
         end
      end
      frame_bits.delete();
   endtask

   task automatic model_field(input logic [7:0] d, input int c, input bit l);
      for (int i = 0; i < c; i++) frame_bits.push_back(d[7-i]);
      if (l) emit_frame();
   endtask

   task automatic send(input logic [7:0] d, input int c, input bit l, input bit use_model);
      int  k = 0;
      bit  acc = 1'b0;
      in_valid = 1'b1; in_data = d; in_count = CW'(c); in_last = l;
      while (!acc && k < 200) begin
         @(negedge clk);
         acc = in_ready;
         tick();
         k++;
      end
      in_valid = 1'b0;
      if (!acc) check("send_timeout", 64'(0), 64'(1));
      if (acc && use_model) model_field(d, (c > 8) ? 8 : c, l);
   endtask

   task automatic wait_words(input int n);
      int k = 0;
      while (act_q.size() < n && k < 3000) begin tick(); k++; end
      if (act_q.size() < n) check("word_timeout", 64'(act_q.size()), 64'(n));
   endtask

   task automatic compare_all(input string name);
      word_t a, e;
      wait_words(exp_q.size());
      repeat (3) tick();
      check({name, "_nwords"}, 64'(act_q.size()), 64'(exp_q.size()));
      while (act_q.size() > 0 && exp_q.size() > 0) begin
         a = act_q.pop_front();
         e = exp_q.pop_front();
         check({name, "_data"},  64'(a.data),  64'(e.data));
         check({name, "_count"}, 64'(a.count), 64'(e.count));
         check({name, "_last"},  64'(a.last),  64'(e.last));
      end
      act_q.delete();
      exp_q.delete();
   endtask

   initial begin
      word_t w;
      int    acc, drops;

      tbl[0].n = 4; tbl[0].d = {8'hD4, 8'hC3, 8'hB2, 8'hA1}; tbl[0].c = {4'd8, 4'd8, 4'd8, 4'd8};
      tbl[0].e_data = 32'hA1B2C3D4; tbl[0].e_cnt = 32;
      tbl[1].n = 2; tbl[1].d = {8'h00, 8'h00, 8'hDF, 8'hA5}; tbl[1].c = {4'd0, 4'd0, 4'd2, 4'd3};
      tbl[1].e_data = 32'hB8000000; tbl[1].e_cnt = 5;
      tbl[2].n = 1; tbl[2].d = {8'h00, 8'h00, 8'h00, 8'hFF}; tbl[2].c = {4'd0, 4'd0, 4'd0, 4'd0};
      tbl[2].e_data = 32'h0; tbl[2].e_cnt = 0;
      tbl[3].n = 2; tbl[3].d = {8'h00, 8'h00, 8'hFF, 8'hFF}; tbl[3].c = {4'd0, 4'd0, 4'd4, 4'd4};
      tbl[3].e_data = 32'hFF000000; tbl[3].e_cnt = 8;
      tbl[4].n = 3; tbl[4].d = {8'h00, 8'h40, 8'h7F, 8'h80}; tbl[4].c = {4'd0, 4'd2, 4'd8, 4'd1};
      tbl[4].e_data = 32'hBFA00000; tbl[4].e_cnt = 11;

      reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_count = '0; in_last = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out_last",  64'(out_last),  64'(0));
      check("rst_out_count", 64'(out_count), 64'(0));
      check("rst_out_data",  64'(out_data),  64'(0));
      check("rst_in_ready",  64'(in_ready),  64'(1));
`ifdef C_BIT_PACKER_CHECK_EN
      check("rst_error", 64'(error), 64'(0));
`endif

      // Directed single-word frames.
      out_ready = 1'b1;
      for (int v = 0; v < 5; v++) begin
         for (int f = 0; f < tbl[v].n; f++)
            send(tbl[v].d[f], int'(tbl[v].c[f]), (f == tbl[v].n-1), 1'b0);
         wait_words(1);
         tick();
         if (act_q.size() > 0) begin
            w = act_q.pop_front();
            check($sformatf("vec%0d_data", v),  64'(w.data),  64'(tbl[v].e_data));
            check($sformatf("vec%0d_count", v), 64'(w.count), 64'(tbl[v].e_cnt));
            check($sformatf("vec%0d_last", v),  64'(w.last),  64'(1));
         end
         check($sformatf("vec%0d_nwords", v), 64'(act_q.size()), 64'(0));
         check($sformatf("vec%0d_ready", v),  64'(in_ready),     64'(1));
         act_q.delete();
      end

      // Backpressure: buffer fills to 64 bits, then drains in order.
      out_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 12; i++) begin
         logic [7:0] d = 8'($urandom);
         in_valid = 1'b1; in_data = d; in_count = CW'(8); in_last = 1'b0;
         @(negedge clk);
         if (in_ready) begin acc++; model_field(d, 8, 1'b0); end
         tick();
      end
      in_valid = 1'b0;
      check("bp_accepted", 64'(acc), 64'(8));
      check("bp_in_ready", 64'(in_ready), 64'(0));
      out_ready = 1'b1;
      send(8'h12, 8, 1'b0, 1'b1);
      send(8'h34, 8, 1'b0, 1'b1);
      send(8'h56, 8, 1'b1, 1'b1);
      compare_all("bp");

      // Streaming throughput: one field per cycle, one word every 4 cycles.
      drops = 0;
      for (int i = 0; i < 32; i++) begin
         logic [7:0] d = 8'($urandom);
         in_valid = 1'b1; in_data = d; in_count = CW'(8); in_last = (i == 31);
         @(negedge clk);
         if (in_ready) model_field(d, 8, (i == 31));
         else drops++;
         tick();
      end
      in_valid = 1'b0;
      check("stream_drops", 64'(drops), 64'(0));
      wait_words(8);
      for (int i = 0; i + 1 < 8 && i + 1 < act_q.size(); i++)
         check($sformatf("stream_gap%0d", i), 64'(act_q[i+1].cyc - act_q[i].cyc), 64'(4));
      compare_all("stream");

      // Mid-frame reset discards 20 buffered bits.
      out_ready = 1'b0;
      send(8'hA5, 8, 1'b0, 1'b0);
      send(8'h3C, 8, 1'b0, 1'b0);
      send(8'hF0, 4, 1'b0, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      check("prst_out_valid", 64'(out_valid), 64'(0));
      check("prst_out_count", 64'(out_count), 64'(0));
      check("prst_out_data",  64'(out_data),  64'(0));
      check("prst_in_ready",  64'(in_ready),  64'(1));
      @(negedge clk);
      #2 reset_n = 1'b1;
      act_q.delete();
      frame_bits.delete();
      tick();
      out_ready = 1'b1;
      send(8'hA1, 8, 1'b1, 1'b1);
      compare_all("prst");

`ifdef C_BIT_PACKER_CHECK_EN
      send(8'hFF, 9, 1'b1, 1'b1);
      compare_all("clamp");
      check("err_set", 64'(error), 64'(1));
      send(8'h81, 8, 1'b1, 1'b1);
      compare_all("post_err");
      check("err_sticky", 64'(error), 64'(1));
`endif

      // Randomized traffic with random backpressure.
      rnd_ready = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) != 0)
            send(8'($urandom), $urandom_range(0, 8), ($urandom_range(0, 7) == 0), 1'b1);
         else
            tick();
      end
      send(8'($urandom), $urandom_range(0, 8), 1'b1, 1'b1);
      rnd_ready = 1'b0;
      tick();
      out_ready = 1'b1;
      compare_all("rand");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
